// File: rtl/seg_mux_nbit.sv
// N-digit multiplexed 7-segment driver: iterative binary->BCD, atomic commit, PWM-dimmed scan.
// Optional leading-zero blanking when SEG_MUX_LZB_EN is defined.
module seg_glyph (
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  input  logic       ovf,
  output logic [7:0] seg
);
  logic [7:0] g;
  always_comb begin
    g = 8'hFF;
    if (ovf)        g = 8'hFD;
    else if (blank) g = 8'hFF;
    else begin
      case (bcd)
        4'd0: g = 8'h03;
        4'd1: g = 8'h9F;
        4'd2: g = 8'h25;
        4'd3: g = 8'h0D;
        4'd4: g = 8'h99;
        4'd5: g = 8'h49;
        4'd6: g = 8'h41;
        4'd7: g = 8'h1F;
        4'd8: g = 8'h01;
        4'd9: g = 8'h09;
        default: g = 8'hFF;
      endcase
    end
    seg = {g[7:1], g[0] & ~dp};
  end
endmodule

module seg_mux_nbit #(
  parameter int DIGITS   = 4,
  parameter int W        = 8,
  parameter int PRESCALE = 500000,
  parameter int PWM_BITS = 3
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                LOAD,
  input  logic [W-1:0]        BIN_IN,
  input  logic [DIGITS-1:0]   DP_IN,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                BUSY,
  output logic                OVF,
  output logic [7:0]          SEG,
  output logic [DIGITS-1:0]   AN
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                   state;
  logic [W-1:0]             bin_sr;
  logic [BW-1:0]            bcd_sr;
  logic [CW-1:0]            cnt;
  logic                     ovf_pend;
  logic [DIGITS-1:0]        dp_pend;
  logic [DIGITS-1:0][3:0]   disp;
  logic [DIGITS-1:0]        dp_reg;
  logic                     ovf_r;
  logic [IW-1:0]            idx;
  logic [PW-1:0]            pre;
  logic [PWM_BITS-1:0]      pwm;
  logic [7:0]               seg_r;
  logic [DIGITS-1:0]        an_r;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
  logic [DIGITS-1:0][3:0]   adj;
  logic [BW-1:0]            adj_flat;
  logic [BW-1:0]            bcd_next;
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++)
      if (adj[i] >= 4'd5) adj[i] = adj[i] + 4'd3;
  end
  assign adj_flat = adj;
  assign bcd_next = {adj_flat[BW-2:0], bin_sr[W-1]};

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      dp_pend  <= '0;
      disp     <= '0;
      dp_reg   <= '0;
      ovf_r    <= 1'b0;
    end else if (CE) begin
      case (state)
        IDLE: if (LOAD) begin
          bin_sr   <= BIN_IN;
          bcd_sr   <= '0;
          cnt      <= '0;
          ovf_pend <= (32'(BIN_IN) >= LIMIT);
          dp_pend  <= DP_IN;
          state    <= CONV;
        end
        CONV: begin
          bcd_sr <= bcd_next;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp   <= bcd_sr;
          dp_reg <= dp_pend;
          ovf_r  <= ovf_pend;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);
  assign OVF  = ovf_r;

  logic [DIGITS-1:0] blank;
`ifdef SEG_MUX_LZB_EN
  logic hi_zero;
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      hi_zero  = hi_zero & (disp[i] == 4'd0);
      blank[i] = hi_zero & ~ovf_r;
    end
  end
`else
  assign blank = '0;
`endif

  logic [DIGITS-1:0][7:0] seg_all;
  for (genvar g = 0; g < DIGITS; g++) begin : g_glyph
    seg_glyph u_glyph (
      .bcd  (disp[g]),
      .dp   (dp_reg[g]),
      .blank(blank[g]),
      .ovf  (ovf_r),
      .seg  (seg_all[g])
    );
  end

  logic [7:0]        sel_seg;
  logic [DIGITS-1:0] onehot;
  always_comb begin
    sel_seg = 8'hFF;
    onehot  = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) begin
        sel_seg   = seg_all[i];
        onehot[i] = 1'b1;
      end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      idx   <= '0;
      pre   <= '0;
      pwm   <= '0;
      seg_r <= 8'hFF;
      an_r  <= '1;
    end else if (CE) begin
      pwm <= pwm + 1'b1;
      if (pre == PW'(PRESCALE - 1)) begin
        pre <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      seg_r <= sel_seg;
      an_r  <= ~(onehot & {DIGITS{pwm <= BRIGHT}});
    end
  end

  assign SEG = seg_r;
  assign AN  = an_r;
endmodule

// File: tb/tb_seg_mux_nbit.sv
// Scoreboard bench for seg_mux_nbit: a 4-digit and a 2-digit instance share stimulus.
module tb_seg_mux_nbit;
  logic       CLK = 1'b0;
  logic       CLR, CE, LOAD;
  logic [7:0] BIN_IN;
  logic [3:0] DP_IN;
  logic [1:0] BRIGHT;
  logic       BUSY, OVF, BUSY2, OVF2;
  logic [7:0] SEG, SEG2;
  logic [3:0] AN;
  logic [1:0] AN2;

  always #5 CLK = ~CLK;

  seg_mux_nbit #(.DIGITS(4), .W(8), .PRESCALE(16), .PWM_BITS(2)) u4 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .BIN_IN(BIN_IN), .DP_IN(DP_IN),
    .BRIGHT(BRIGHT), .BUSY(BUSY), .OVF(OVF), .SEG(SEG), .AN(AN));

  seg_mux_nbit #(.DIGITS(2), .W(8), .PRESCALE(16), .PWM_BITS(2)) u2 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .BIN_IN(BIN_IN), .DP_IN(DP_IN[1:0]),
    .BRIGHT(BRIGHT), .BUSY(BUSY2), .OVF(OVF2), .SEG(SEG2), .AN(AN2));

  typedef struct {
    logic [3:0][7:0] seg4;
    logic [1:0][7:0] seg2;
    logic            ovf4;
    logic            ovf2;
    int              busy;
  } exp_t;

  localparam logic [7:0] GTAB [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                       8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  bit   abort = 1'b0;
  bit   mon_busy = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digit i of v, with overflow dash and optional leading-zero blank
  function automatic logic [7:0] glyph(int v, bit dp, int i, int digits);
    int p = 1, lim = 1;
    logic [7:0] g;
    for (int k = 0; k < i; k++) p *= 10;
    for (int k = 0; k < digits; k++) lim *= 10;
    if (v >= lim) g = 8'hFD;
    else begin
      g = GTAB[(v / p) % 10];
`ifdef SEG_MUX_LZB_EN
      if (i > 0 && v < p) g = 8'hFF;
`endif
    end
    if (dp) g[0] = 1'b0;
    return g;
  endfunction

  // Monitor: on each commit (BUSY falling) pop the expectation, then watch one full scan
  initial begin
    int bc = 0, win = 0;
    bit prev = 1'b0;
    exp_t e;
    logic [3:0][7:0] s4;
    logic [1:0][7:0] s2;
    bit [3:0] seen4;
    bit [1:0] seen2;
    logic [3:0] m4;
    logic [1:0] m2;
    forever begin
      @(negedge CLK);
      if (win > 0) begin
        for (int d = 0; d < 4; d++) begin
          m4 = 4'b0001 << d;
          if (AN == ~m4) begin s4[d] = SEG; seen4[d] = 1'b1; end
        end
        for (int d = 0; d < 2; d++) begin
          m2 = 2'b01 << d;
          if (AN2 == ~m2) begin s2[d] = SEG2; seen2[d] = 1'b1; end
        end
        win--;
        if (win == 0) begin
          for (int d = 0; d < 4; d++)
            check($sformatf("u4 digit%0d", d), seen4[d] ? {24'd0, s4[d]} : 32'hDEAD, {24'd0, e.seg4[d]});
          for (int d = 0; d < 2; d++)
            check($sformatf("u2 digit%0d", d), seen2[d] ? {24'd0, s2[d]} : 32'hDEAD, {24'd0, e.seg2[d]});
          mon_busy = 1'b0;
        end
      end
      if (BUSY) bc++;
      else if (prev) begin
        if (abort) abort = 1'b0;
        else if (q.size() == 0) check("unexpected commit", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("busy cycles", bc, e.busy);
          check("u4 ovf", {31'd0, OVF}, {31'd0, e.ovf4});
          check("u2 ovf", {31'd0, OVF2}, {31'd0, e.ovf2});
          seen4 = '0; seen2 = '0;
          win = 72;
          mon_busy = 1'b1;
        end
        bc = 0;
      end
      prev = BUSY;
    end
  end

  task automatic do_load(int v, logic [3:0] dp, int stall, bit push);
    exp_t e;
    @(negedge CLK);
    BIN_IN = v[7:0]; DP_IN = dp; LOAD = 1'b1;
    if (push) begin
      for (int d = 0; d < 4; d++) e.seg4[d] = glyph(v, dp[d], d, 4);
      for (int d = 0; d < 2; d++) e.seg2[d] = glyph(v, dp[d], d, 2);
      e.ovf4 = (v >= 10000);
      e.ovf2 = (v >= 100);
      e.busy = 9 + stall;
      q.push_back(e);
    end
    @(negedge CLK);
    LOAD = 1'b0;
    if (stall > 0) begin
      CE = 1'b0;
      repeat (stall) @(negedge CLK);
      CE = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || mon_busy || BUSY) && t < 400) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 400) check("wait_idle timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lit, trans, bad, pidx, cidx;
    CLR = 1'b1; CE = 1'b1; LOAD = 1'b0; BIN_IN = '0; DP_IN = '0; BRIGHT = 2'd3;
    repeat (3) @(negedge CLK);
    check("reset SEG", {24'd0, SEG}, 32'hFF);
    check("reset AN", {28'd0, AN}, 32'hF);
    check("reset BUSY", {31'd0, BUSY}, 32'd0);
    check("reset OVF", {31'd0, OVF}, 32'd0);
    check("reset SEG2", {24'd0, SEG2}, 32'hFF);
    check("reset AN2", {30'd0, AN2}, 32'h3);
    CLR = 1'b0;

    do_load(255, 4'b0000, 0, 1'b1); wait_idle();
    do_load(0,   4'b0100, 0, 1'b1); wait_idle();
    do_load(100, 4'b0000, 0, 1'b1); wait_idle();
    do_load(99,  4'b0000, 0, 1'b1); wait_idle();
    do_load(100, 4'b0011, 0, 1'b1); wait_idle();
    // second LOAD lands while busy and must be dropped
    do_load(12,  4'b0000, 0, 1'b1);
    do_load(200, 4'b1111, 0, 1'b0);
    wait_idle();
    for (int n = 0; n < 8; n++) begin
      do_load($urandom_range(0, 255), 4'($urandom_range(0, 15)), $urandom_range(0, 4), 1'b1);
      wait_idle();
    end

    do_load(150, 4'b0000, 0, 1'b1); wait_idle();
    abort = 1'b1;
    do_load(42, 4'b0001, 0, 1'b0);
    repeat (2) @(negedge CLK);
    #2 CLR = 1'b1;
    #1;
    check("clr SEG", {24'd0, SEG}, 32'hFF);
    check("clr AN", {28'd0, AN}, 32'hF);
    check("clr BUSY", {31'd0, BUSY}, 32'd0);
    check("clr OVF", {31'd0, OVF}, 32'd0);
    check("clr OVF2", {31'd0, OVF2}, 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    repeat (3) @(negedge CLK);

    BRIGHT = 2'd0;
    repeat (4) @(negedge CLK);
    lit = 0; bad = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      if (AN != 4'hF) begin
        lit++;
        if (!$onehot(~AN)) bad++;
      end
    end
    check("bright0 lit cycles", lit, 16);
    check("bright0 onehot", bad, 0);

    BRIGHT = 2'd3;
    repeat (4) @(negedge CLK);
    lit = 0; trans = 0; bad = 0; pidx = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (AN != 4'hF) lit++;
      cidx = -1;
      for (int d = 0; d < 4; d++) if (AN == ~(4'(1) << d)) cidx = d;
      if (cidx < 0) bad++;
      else if (pidx >= 0 && cidx != pidx) begin
        trans++;
        if (cidx != (pidx + 1) % 4) bad++;
      end
      pidx = cidx;
    end
    check("bright3 lit cycles", lit, 80);
    check("scan order errors", bad, 0);
    check("scan transitions", {31'd0, trans >= 4}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_mux_nbit.md
# seg_mux_nbit

Parametrised multiplexed 7-segment display driver: next generation of the 8-bit four-digit driver, generalised to N digits and W-bit binary input. Converts binary to BCD with an iterative double-dabble engine behind a LOAD/BUSY handshake, commits the result atomically to a display register, and scans digits with per-slot PWM brightness, per-digit decimal points and overflow indication. Sits between synth status logic (note, value readouts) and the board's common-anode display pins.

## Interface
- DIGITS, 4: number of digits and anodes; 1..8.
- W, 8: binary input width; 1..26.
- PRESCALE, 500000: CLK cycles (with CE) per digit slot; must be a multiple of 2**PWM_BITS.
- PWM_BITS, 3: brightness resolution.
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous, active-high reset.
- CE  in  1  global clock enable; low freezes every register.
- LOAD  in  1  start conversion of BIN_IN.
- BIN_IN  in  W  unsigned value to display.
- DP_IN  in  DIGITS  decimal point per digit, 1 = lit; sampled with BIN_IN.
- BRIGHT  in  PWM_BITS  duty = (BRIGHT+1)/2**PWM_BITS.
- BUSY  out  1  conversion in progress.
- OVF  out  1  committed value ≥ 10**DIGITS.
- SEG  out  8  active low; SEG[7:1] = a,b,c,d,e,f,g, SEG[0] = DP.
- AN  out  DIGITS  active low; AN[0] = rightmost (least significant) digit.

## Operation
- Reset values: SEG = 8'hFF, AN = all ones, BUSY = 0, OVF = 0, display register = 0, DP register = 0, digit index 0, prescaler and PWM counters 0, FSM IDLE.
- FSM: IDLE → CONV on LOAD && CE; CONV runs W shift/add-3 steps (one per CE cycle); COMMIT for one cycle, then IDLE. BUSY = (state != IDLE).
- LOAD while BUSY: ignored, no queueing. LOAD and commit never overlap.
- Overflow: BIN_IN compared against 10**DIGITS at LOAD; flag held through CONV, written to OVF in COMMIT. With OVF = 1 every digit shows "-" (8'hFD), DP still applied.
- COMMIT writes BCD digits, DP register and OVF in one edge; scanning shows the old value until then.
- Scan: prescaler tick every PRESCALE CE cycles advances digit index 0..DIGITS-1, wraps to 0.
- PWM: PWM_BITS counter increments every CE cycle; selected anode driven low only while counter ≤ BRIGHT; BRIGHT = max → 100 % duty. SEG always driven for the selected digit.
- Glyphs: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09 (hex, DP off); DP lit clears bit 0.
- CLR mid-conversion: aborts, all state to reset values.

## Timing
- LOAD sampled at edge 0 (CE = 1, IDLE); BUSY high after edge 0 through edge W+1: W+1 CE cycles. New value visible from edge W+1.
- CE low stretches all latencies; counts are in CE cycles.
- AN and SEG are registered: change one CLK after the tick/PWM condition.
- Anode switch and segment update occur on the same edge; no ghosting window beyond one cycle.

## Configuration
- SEG_MUX_LZB_EN defined: leading-zero blanking; digits above the most significant nonzero digit show 8'hFF (8'hFE if DP lit); digit 0 never blanked; no blanking while OVF = 1.
- Undefined: all digits display, including leading zeros.

## Test plan
Bench parameters: DIGITS=4, W=8, PRESCALE=16, PWM_BITS=2, SEG_MUX_LZB_EN defined unless stated.
- CLR pulse mid-CONV → SEG=8'hFF, AN=4'hF, BUSY=0, OVF=0 immediately, asynchronously.
- LOAD BIN_IN=255, DP_IN=0 → BUSY high exactly 9 cycles; scan shows digit0=8'h49, digit1=8'h49, digit2=8'h25, digit3=8'hFF; same with LZB undefined → digit3=8'h03.
- BIN_IN=0, DP_IN=4'b0100 → digit0=8'h03, digit1=8'hFF, digit2=8'hFE, digit3=8'hFF.
- DIGITS=2 build, BIN_IN=100 → OVF=1, both digits 8'hFD; then BIN_IN=99 → OVF=0, 8'h09 on both.
- LOAD 12 then LOAD 200 two cycles later → second ignored; display shows 12 (digit0=8'h25, digit1=8'h9F).
- BRIGHT=0 → selected anode low 1 of every 4 cycles; BRIGHT=3 → low for the whole 16-cycle slot; index order 0,1,2,3,0.
